// File: rtl/sramlike2axi_bridge.sv
// rtl/sramlike2axi_bridge.sv - inst/data SRAM-like masters onto one single-beat AXI3 master port
// Optional AXI_BRIDGE_ERR_EN adds a sticky bus_err output for non-OKAY rresp/bresp.
module sramlike2axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
`ifdef AXI_BRIDGE_ERR_EN
    ,
    output logic        bus_err
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B} state_t;

    state_t      state, state_n;
    logic        owner_data;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        aw_done, aw_done_n;
    logic        w_done, w_done_n;
    logic        accept;

    assign accept = (state == S_IDLE) && (data_req || inst_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner_data <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            if (accept) begin
                owner_data <= data_req;
                size_q     <= data_req ? data_size  : inst_size;
                addr_q     <= data_req ? data_addr  : inst_addr;
                wdata_q    <= data_req ? data_wdata : 32'd0;
            end
        end
    end

    // Every handshake output is gated by rst so a reset mid-transaction drops it the same cycle.
    always_comb begin
        state_n      = state;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        arvalid      = 1'b0;
        rready       = 1'b0;
        awvalid      = 1'b0;
        wvalid       = 1'b0;
        bready       = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE: begin
                    if (data_req) begin
                        data_addr_ok = 1'b1;
                        state_n      = data_wr ? S_AW_W : S_AR;
                    end else if (inst_req) begin
                        inst_addr_ok = 1'b1;
                        state_n      = S_AR;
                    end
                end
                S_AR: begin
                    arvalid = 1'b1;
                    if (arready) state_n = S_R;
                end
                S_R: begin
                    rready = 1'b1;
                    if (rvalid) begin
                        data_data_ok = owner_data;
                        inst_data_ok = !owner_data;
                        state_n      = S_IDLE;
                    end
                end
                S_AW_W: begin
                    awvalid = !aw_done;
                    wvalid  = !w_done;
                    if (!aw_done && awready) aw_done_n = 1'b1;
                    if (!w_done && wready)   w_done_n  = 1'b1;
                    if (aw_done_n && w_done_n) begin
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                        state_n   = S_B;
                    end
                end
                S_B: begin
                    bready = 1'b1;
                    if (bvalid) begin
                        data_data_ok = 1'b1;
                        state_n      = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        wstrb = 4'b1111;
        case (size_q)
            2'd0:    wstrb = 4'b0001 << addr_q[1:0];
            2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    assign arid    = owner_data ? DATA_ID : INST_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, size_q};
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;

    assign awid    = DATA_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, size_q};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;

    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wlast   = 1'b1;

    assign inst_rdata = rdata;
    assign data_rdata = rdata;

`ifdef AXI_BRIDGE_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if ((rready && rvalid && rresp != 2'b00) ||
                     (bready && bvalid && bresp != 2'b00)) begin
            bus_err <= 1'b1;
        end
    end

    logic unused_in;
    assign unused_in = &{1'b0, inst_wr, inst_wdata, rid, rlast, bid};
`else
    logic unused_in;
    assign unused_in = &{1'b0, inst_wr, inst_wdata, rid, rlast, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_sramlike2axi_bridge.sv
// tb/tb_sramlike2axi_bridge.sv - directed table-driven bench for sramlike2axi_bridge
module tb_sramlike2axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef AXI_BRIDGE_ERR_EN
    logic        bus_err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sramlike2axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef AXI_BRIDGE_ERR_EN
        , .bus_err(bus_err)
`endif
    );

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  exp_id;
        logic [2:0]  exp_size;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        if (v.is_data) begin
            data_req = 1; data_wr = v.wr; data_size = v.size; data_addr = v.addr; data_wdata = v.wdata;
        end else begin
            inst_req = 1; inst_wr = v.wr; inst_size = v.size; inst_addr = v.addr;
        end
        #1;
        chk($sformatf("v%0d addr_ok", i), {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, !v.is_data, v.is_data});
        step();
        data_req = 0; inst_req = 0;
        if (v.is_data && v.wr) begin
            awready = 1; wready = 1;
            #1;
            chk($sformatf("v%0d aw/w valid", i), {30'd0, awvalid, wvalid}, 32'd3);
            chk($sformatf("v%0d awaddr", i), awaddr, v.addr);
            chk($sformatf("v%0d awsize", i), {29'd0, awsize}, {29'd0, v.exp_size});
            chk($sformatf("v%0d wstrb", i), {28'd0, wstrb}, {28'd0, v.exp_wstrb});
            chk($sformatf("v%0d wdata", i), wdata, v.wdata);
            chk($sformatf("v%0d ids/last/len", i), {awid, wid, wlast, awlen, awburst},
                {4'd1, 4'd1, 1'b1, 8'd0, 2'b01});
            step();
            awready = 0; wready = 0; bvalid = 1;
            #1;
            chk($sformatf("v%0d bready/ok", i), {29'd0, bready, data_data_ok, inst_data_ok}, 32'd6);
            step();
            bvalid = 0;
        end else begin
            arready = 1;
            #1;
            chk($sformatf("v%0d arvalid", i), {31'd0, arvalid}, 32'd1);
            chk($sformatf("v%0d araddr", i), araddr, v.addr);
            chk($sformatf("v%0d arid", i), {28'd0, arid}, {28'd0, v.exp_id});
            chk($sformatf("v%0d arsize", i), {29'd0, arsize}, {29'd0, v.exp_size});
            chk($sformatf("v%0d arlen/burst", i), {arlen, arburst}, {8'd0, 2'b01});
            chk($sformatf("v%0d no aw", i), {31'd0, awvalid}, 32'd0);
            step();
            arready = 0; rvalid = 1; rdata = v.rdata;
            #1;
            chk($sformatf("v%0d rready/ok", i), {29'd0, rready, data_data_ok, inst_data_ok},
                {29'd0, 1'b1, v.is_data, !v.is_data});
            chk($sformatf("v%0d rdata", i), v.is_data ? data_rdata : inst_rdata, v.rdata);
            step();
            rvalid = 0;
        end
        #1;
        chk($sformatf("v%0d back idle", i), {28'd0, rready, bready, inst_data_ok, data_data_ok}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'd2, 32'hBFC00000, 32'h0, 32'h3C1D0001, 4'd0, 3'd2, 4'b0000};
        vecs[1] = '{1'b1, 1'b0, 2'd1, 32'h80000002, 32'h0, 32'h12345678, 4'd1, 3'd1, 4'b0000};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 32'h00001003, 32'hAA000000, 32'h0, 4'd1, 3'd0, 4'b1000};
        vecs[3] = '{1'b1, 1'b1, 2'd0, 32'h00001000, 32'h000000BB, 32'h0, 4'd1, 3'd0, 4'b0001};
        vecs[4] = '{1'b1, 1'b1, 2'd0, 32'h00001001, 32'h0000CC00, 32'h0, 4'd1, 3'd0, 4'b0010};
        vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h00002002, 32'h55660000, 32'h0, 4'd1, 3'd1, 4'b1100};
        vecs[6] = '{1'b1, 1'b1, 2'd1, 32'h00002000, 32'h00007788, 32'h0, 4'd1, 3'd1, 4'b0011};
        vecs[7] = '{1'b1, 1'b1, 2'd2, 32'h00003004, 32'hDEADBEEF, 32'h0, 4'd1, 3'd2, 4'b1111};

        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        #1;
        chk("reset valids", {24'd0, arvalid, rready, awvalid, wvalid, bready,
            inst_addr_ok, inst_data_ok, data_addr_ok}, 32'd0);
        chk("reset regs", araddr ^ wdata, 32'd0);
        chk("reset data_ok", {31'd0, data_data_ok}, 32'd0);

        // boot fetch with arready one cycle late and rvalid two cycles after
        inst_req = 1; inst_size = 2; inst_addr = 32'hBFC00000;
        #1;
        chk("boot c0 inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        step();
        inst_req = 0; arready = 1;
        #1;
        chk("boot c1 ar", {arvalid, arid, arsize}, {1'b1, 4'd0, 3'd2});
        chk("boot c1 araddr", araddr, 32'hBFC00000);
        step();
        arready = 0;
        #1;
        chk("boot c2 waiting", {30'd0, rready, inst_data_ok}, 32'd2);
        step();
        rvalid = 1; rdata = 32'h3C1D0001;
        #1;
        chk("boot c3 data_ok", {31'd0, inst_data_ok}, 32'd1);
        chk("boot c3 rdata", inst_rdata, 32'h3C1D0001);
        step();
        rvalid = 0;

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // data beats inst; inst waits until the cycle after data_data_ok
        inst_req = 1; inst_addr = 32'h00000040; inst_size = 2;
        data_req = 1; data_wr = 0; data_addr = 32'h00000080; data_size = 2;
        #1;
        chk("arb addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
        step();
        data_req = 0; arready = 1;
        #1;
        chk("arb busy inst", {28'd0, inst_addr_ok, arvalid, arid}, {28'd0, 1'b0, 1'b1, 4'd1} >> 0);
        step();
        arready = 0; rvalid = 1; rdata = 32'hCAFE0001;
        #1;
        chk("arb data_ok only", {29'd0, data_data_ok, inst_data_ok, inst_addr_ok}, 32'd4);
        step();
        rvalid = 0;
        #1;
        chk("arb inst accepted", {31'd0, inst_addr_ok}, 32'd1);
        step();
        inst_req = 0; arready = 1;
        #1;
        chk("arb inst ar", {arvalid, arid}, {1'b1, 4'd0});
        chk("arb inst araddr", araddr, 32'h00000040);
        step();
        arready = 0; rvalid = 1;
        #1;
        chk("arb inst data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
        step();
        rvalid = 0;

        // awready two cycles ahead of wready
        data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h00000003; data_wdata = 32'hAA000000;
        #1;
        chk("split addr_ok", {31'd0, data_addr_ok}, 32'd1);
        step();
        data_req = 0; awready = 1;
        #1;
        chk("split c1", {26'd0, awvalid, wvalid, wstrb}, {26'd0, 1'b1, 1'b1, 4'b1000});
        chk("split c1 awsize", {29'd0, awsize}, 32'd0);
        step();
        awready = 0;
        #1;
        chk("split c2", {29'd0, awvalid, wvalid, bready}, 32'd2);
        step();
        wready = 1;
        #1;
        chk("split c3", {30'd0, awvalid, wvalid}, 32'd1);
        step();
        wready = 0;
        #1;
        chk("split c4 B wait", {29'd0, bready, data_data_ok, wvalid}, 32'd4);
        step();
        bvalid = 1;
        #1;
        chk("split c5 data_ok", {31'd0, data_data_ok}, 32'd1);
        step();
        bvalid = 0;
        #1;
        chk("split c6 done", {30'd0, data_data_ok, bready}, 32'd0);

        // reset while waiting in R
        inst_req = 1; inst_addr = 32'h00000100;
        step();
        inst_req = 0; arready = 1;
        step();
        arready = 0;
        #1;
        chk("rst pre R", {31'd0, rready}, 32'd1);
        rst = 1; rvalid = 1;
        #1;
        chk("rst in R", {30'd0, rready, inst_data_ok}, 32'd0);
        step();
        rst = 0; rvalid = 0;
        #1;
        chk("rst after", {29'd0, rready, arvalid, inst_data_ok}, 32'd0);
        inst_req = 1; inst_addr = 32'h00000200;
        #1;
        chk("rst new req", {31'd0, inst_addr_ok}, 32'd1);
        step();
        inst_req = 0; arready = 1;
        #1;
        chk("rst new araddr", araddr, 32'h00000200);
        step();
        arready = 0; rvalid = 1;
        #1;
        chk("rst new data_ok", {31'd0, inst_data_ok}, 32'd1);
        step();
        rvalid = 0;

`ifdef AXI_BRIDGE_ERR_EN
        #1;
        chk("err initial", {31'd0, bus_err}, 32'd0);
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h10; data_wdata = 32'h1;
        step();
        data_req = 0; awready = 1; wready = 1;
        step();
        awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
        #1;
        chk("err data_ok", {31'd0, data_data_ok}, 32'd1);
        step();
        bvalid = 0; bresp = 0;
        #1;
        chk("err set", {31'd0, bus_err}, 32'd1);
        inst_req = 1; inst_addr = 32'h20;
        step();
        inst_req = 0; arready = 1;
        step();
        arready = 0; rvalid = 1;
        step();
        rvalid = 0;
        #1;
        chk("err sticky", {31'd0, bus_err}, 32'd1);
        rst = 1;
        step();
        rst = 0;
        #1;
        chk("err cleared", {31'd0, bus_err}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
